execute_mem_wbarb: RTL and testbench
====================================

Name: execute_mem_wbarb

Overview:
- Arbitrates the single memory-stage writeback slot between two requesters: the load/store hit pipeline (port 0) and the miss-refill return path (port 1).
- At most one winner per cycle. The winner's payload is registered and driven to the memory-stage output flop stage, then on to ROB writeback.
- Port 0 has fixed priority. A starvation counter forces a port-1 grant after STARVE_MAX consecutive losses.
- Flush support discards in-flight output on pipeline redirect.

Parameters:
- STARVE_MAX, 3, consecutive cycles port 1 may lose while valid before it is force-granted (legal range 1..15, 4-bit counter).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- i_flush  in  1  pipeline redirect; discard this cycle's arbitration and the output register
- i_req0_valid  in  1  hit-pipeline request
- o_req0_ready  out  1  port-0 grant this cycle (combinational)
- i_req0_dst_rob  in  4  destination ROB index
- i_req0_fid  in  8  fetch id
- i_req0_result  in  32  load data / store result
- i_req0_cmtdelay  in  4  commit delay
- i_req0_lsmiss  in  1  load/store miss flag
- i_req1_valid  in  1  refill request
- o_req1_ready  out  1  port-1 grant this cycle (combinational)
- i_req1_dst_rob  in  4  destination ROB index
- i_req1_fid  in  8  fetch id
- i_req1_result  in  32  refill data
- o_valid  out  1  registered writeback valid
- o_dst_rob  out  4  registered ROB index
- o_fid  out  8  registered fetch id
- o_result  out  32  registered result
- o_cmtdelay  out  4  registered commit delay
- o_lsmiss  out  1  registered miss flag
- o_src  out  1  registered winner id (0/1)
- o_starve_grant  out  1  registered pulse: last grant was a forced port-1 grant

Behaviour:
- Reset (reset=1 at a clk edge):
  - All registered outputs go to 0.
  - starve_cnt goes to 0.
  - Readies are 0 while reset is high.
- Grant logic (combinational, from current inputs and starve_cnt):
  - If i_flush or reset: no grant.
  - Else if req0 and req1 both valid: grant port 1 when starve_cnt == STARVE_MAX; otherwise grant port 0.
  - Else grant the single valid requester.
  - Else no grant.
- o_reqN_ready equals grantN. A request is consumed on valid && ready. A requester that is not granted must hold its payload stable.
- Latency: the granted payload appears on the outputs 1 cycle later with o_valid=1. With no grant, the next cycle has o_valid=0.
- Data registers load only on a grant; otherwise they hold their previous values. o_valid is the only qualifier.
- Port-1 payload mapping:
  - o_cmtdelay = 0.
  - o_lsmiss = 0, because a refill is by definition a resolved miss.
  - o_src = 1.
- Port-0 payload mapping: passed through unchanged, with o_src = 0.
- starve_cnt, 4 bits, saturating at STARVE_MAX:
  - Increments when req1 is valid and port 0 is granted.
  - Clears to 0 on any port-1 grant.
  - Holds when req1 is not valid.
  - Clears on i_flush.
- o_starve_grant = 1 for the cycle following a port-1 grant made while req0 was also valid. Otherwise 0.
- Flush: when i_flush=1 at an edge, o_valid goes to 0 and o_starve_grant goes to 0 next cycle, and no request is consumed. A flush in the same cycle as a grant-eligible request drops the grant.
- Throughput: one writeback per cycle sustained. No bubbles between back-to-back grants.

Test Plan:
- Reset hold, then release with no requests:
  - All outputs are 0 during reset and stay 0 afterwards.
  - Both readies are 0 during reset.
- req0 only, dst_rob=5, fid=0x21, result=0xDEADBEEF, cmtdelay=2, lsmiss=0:
  - o_req0_ready=1 that cycle.
  - Next cycle: o_valid=1, o_dst_rob=5, o_fid=0x21, o_result=0xDEADBEEF, o_cmtdelay=2, o_src=0.
- req1 only, dst_rob=9, result=0x12345678, with req0 idle:
  - Next cycle: o_valid=1, o_src=1, o_cmtdelay=0, o_lsmiss=0, o_starve_grant=0.
- Starvation, STARVE_MAX=3, req0 and req1 held valid for 8 cycles:
  - Grant sequence is 0,0,0,1,0,0,0,1.
  - o_starve_grant pulses one cycle after each port-1 grant.
  - starve_cnt returns to 0 after each port-1 grant.
- Flush: req0 valid with i_flush=1 in the same cycle:
  - o_req0_ready=0, and o_valid=0 next cycle.
  - A pending starve_cnt of 2 is cleared, so the next contention grants port 0 three times before port 1.
- Back-to-back req0 for 4 cycles, then idle:
  - o_valid=1 for exactly 4 consecutive cycles, then 0.
  - Output data holds the last payload.

Source files
------------

// File: rtl/execute_mem_wbarb.sv
// Memory-stage writeback arbiter. Picks one of two requesters per cycle:
// the hit pipeline (port 0) or the refill return path (port 1).
//
// Handshake: a request moves on the cycle where valid && ready are both high
// at the clock edge. Ready is combinational, and a requester that is not
// granted keeps its valid and payload stable until it is granted.
module execute_mem_wbarb #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_flush,
  input  logic        i_req0_valid,
  output logic        o_req0_ready,
  input  logic [3:0]  i_req0_dst_rob,
  input  logic [7:0]  i_req0_fid,
  input  logic [31:0] i_req0_result,
  input  logic [3:0]  i_req0_cmtdelay,
  input  logic        i_req0_lsmiss,
  input  logic        i_req1_valid,
  output logic        o_req1_ready,
  input  logic [3:0]  i_req1_dst_rob,
  input  logic [7:0]  i_req1_fid,
  input  logic [31:0] i_req1_result,
  output logic        o_valid,
  output logic [3:0]  o_dst_rob,
  output logic [7:0]  o_fid,
  output logic [31:0] o_result,
  output logic [3:0]  o_cmtdelay,
  output logic        o_lsmiss,
  output logic        o_src,
  output logic        o_starve_grant
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]  starve_cnt;
  logic [3:0]  starve_nxt;
  logic        grant0;
  logic        grant1;
  logic        contend;
  logic        starve_hit;

  logic [3:0]  win_dst_rob;
  logic [7:0]  win_fid;
  logic [31:0] win_result;
  logic [3:0]  win_cmtdelay;
  logic        win_lsmiss;
  logic        win_src;

  // Grant selection: port 0 wins ties unless port 1 has lost STARVE_MAX in a row.
  always_comb begin
    grant0     = 1'b0;
    grant1     = 1'b0;
    contend    = i_req0_valid && i_req1_valid;
    starve_hit = (starve_cnt == STARVE_LIM);
    if (!(reset || i_flush)) begin
      if (contend) begin
        if (starve_hit) grant1 = 1'b1;
        else            grant0 = 1'b1;
      end else if (i_req0_valid) begin
        grant0 = 1'b1;
      end else if (i_req1_valid) begin
        grant1 = 1'b1;
      end
    end
  end

  assign o_req0_ready = grant0;
  assign o_req1_ready = grant1;

  // Counts consecutive port-1 losses; saturates so it never wraps past the limit.
  always_comb begin
    starve_nxt = starve_cnt;
    if (i_flush || grant1) begin
      starve_nxt = 4'd0;
    end else if (grant0 && i_req1_valid && !starve_hit) begin
      starve_nxt = starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= 4'd0;
    end else begin
      starve_cnt <= starve_nxt;
    end
  end

  // A refill is already a resolved miss with no commit delay of its own.
  always_comb begin
    win_dst_rob  = i_req0_dst_rob;
    win_fid      = i_req0_fid;
    win_result   = i_req0_result;
    win_cmtdelay = i_req0_cmtdelay;
    win_lsmiss   = i_req0_lsmiss;
    win_src      = 1'b0;
    if (grant1) begin
      win_dst_rob  = i_req1_dst_rob;
      win_fid      = i_req1_fid;
      win_result   = i_req1_result;
      win_cmtdelay = 4'd0;
      win_lsmiss   = 1'b0;
      win_src      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      o_valid        <= 1'b0;
      o_starve_grant <= 1'b0;
    end else begin
      o_valid        <= grant0 || grant1;
      o_starve_grant <= grant1 && i_req0_valid;
    end
  end

  // Payload registers only move on a grant; o_valid alone qualifies them.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_dst_rob  <= 4'd0;
      o_fid      <= 8'd0;
      o_result   <= 32'd0;
      o_cmtdelay <= 4'd0;
      o_lsmiss   <= 1'b0;
      o_src      <= 1'b0;
    end else if (grant0 || grant1) begin
      o_dst_rob  <= win_dst_rob;
      o_fid      <= win_fid;
      o_result   <= win_result;
      o_cmtdelay <= win_cmtdelay;
      o_lsmiss   <= win_lsmiss;
      o_src      <= win_src;
    end
  end

endmodule

// File: tb/tb_execute_mem_wbarb.sv
// Bench for execute_mem_wbarb: directed test-plan steps followed by random
// traffic, all checked against a loss-counting reference model.
module tb_execute_mem_wbarb;

  localparam int SM = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_flush;
  logic        i_req0_valid;
  logic        o_req0_ready;
  logic [3:0]  i_req0_dst_rob;
  logic [7:0]  i_req0_fid;
  logic [31:0] i_req0_result;
  logic [3:0]  i_req0_cmtdelay;
  logic        i_req0_lsmiss;
  logic        i_req1_valid;
  logic        o_req1_ready;
  logic [3:0]  i_req1_dst_rob;
  logic [7:0]  i_req1_fid;
  logic [31:0] i_req1_result;
  logic        o_valid;
  logic [3:0]  o_dst_rob;
  logic [7:0]  o_fid;
  logic [31:0] o_result;
  logic [3:0]  o_cmtdelay;
  logic        o_lsmiss;
  logic        o_src;
  logic        o_starve_grant;

  execute_mem_wbarb #(.STARVE_MAX(SM)) dut (
    .clk(clk), .reset(reset), .i_flush(i_flush),
    .i_req0_valid(i_req0_valid), .o_req0_ready(o_req0_ready),
    .i_req0_dst_rob(i_req0_dst_rob), .i_req0_fid(i_req0_fid),
    .i_req0_result(i_req0_result), .i_req0_cmtdelay(i_req0_cmtdelay),
    .i_req0_lsmiss(i_req0_lsmiss),
    .i_req1_valid(i_req1_valid), .o_req1_ready(o_req1_ready),
    .i_req1_dst_rob(i_req1_dst_rob), .i_req1_fid(i_req1_fid),
    .i_req1_result(i_req1_result),
    .o_valid(o_valid), .o_dst_rob(o_dst_rob), .o_fid(o_fid),
    .o_result(o_result), .o_cmtdelay(o_cmtdelay), .o_lsmiss(o_lsmiss),
    .o_src(o_src), .o_starve_grant(o_starve_grant)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Scoreboard: one packed expected output word per clock edge
  logic [51:0] exp_q[$];

  // Reference model state: consecutive port-1 losses and the held payload
  int          m_losses = 0;
  int          m_w = -1;
  logic [3:0]  md_dst = '0;
  logic [7:0]  md_fid = '0;
  logic [31:0] md_res = '0;
  logic [3:0]  md_cd = '0;
  logic        md_ls = 1'b0;
  logic        md_src = 1'b0;
  logic [7:0]  grant1_seq = '0;
  int          valid_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_winner();
    if (reset || i_flush) return -1;
    if (i_req0_valid && i_req1_valid) return (m_losses >= SM) ? 1 : 0;
    if (i_req0_valid) return 0;
    if (i_req1_valid) return 1;
    return -1;
  endfunction

  // One clock: check readies and registered outputs mid-cycle, then advance
  // the model using the inputs that the coming edge will sample.
  task automatic tick(input string tag);
    logic [51:0] e;
    logic        sg;
    @(negedge clk);
    m_w = model_winner();
    chk({tag, "_rdy0"}, 64'(o_req0_ready), 64'(m_w == 0));
    chk({tag, "_rdy1"}, 64'(o_req1_ready), 64'(m_w == 1));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_out"}, 64'({o_valid, o_dst_rob, o_fid, o_result, o_cmtdelay,
                              o_lsmiss, o_src, o_starve_grant}), 64'(e));
    end
    grant1_seq = {grant1_seq[6:0], (m_w == 1)};
    sg = 1'b0;
    if (reset) begin
      {md_dst, md_fid, md_res, md_cd, md_ls, md_src} = '0;
      m_losses = 0;
    end else if (i_flush) begin
      m_losses = 0;
    end else begin
      if (m_w == 0) begin
        {md_dst, md_fid, md_res, md_cd, md_ls, md_src} =
          {i_req0_dst_rob, i_req0_fid, i_req0_result, i_req0_cmtdelay, i_req0_lsmiss, 1'b0};
        if (i_req1_valid && m_losses < SM) m_losses++;
      end else if (m_w == 1) begin
        {md_dst, md_fid, md_res, md_cd, md_ls, md_src} =
          {i_req1_dst_rob, i_req1_fid, i_req1_result, 4'd0, 1'b0, 1'b1};
        sg = i_req0_valid;
        m_losses = 0;
      end
    end
    exp_q.push_back({(m_w >= 0), md_dst, md_fid, md_res, md_cd, md_ls, md_src, sg});
    @(posedge clk);
    #1;
    if (o_valid) valid_cnt++;
  endtask

  task automatic drive0(input logic v, input logic [3:0] d, input logic [7:0] f,
                        input logic [31:0] r, input logic [3:0] c, input logic l);
    i_req0_valid = v; i_req0_dst_rob = d; i_req0_fid = f;
    i_req0_result = r; i_req0_cmtdelay = c; i_req0_lsmiss = l;
  endtask

  task automatic drive1(input logic v, input logic [3:0] d, input logic [7:0] f,
                        input logic [31:0] r);
    i_req1_valid = v; i_req1_dst_rob = d; i_req1_fid = f; i_req1_result = r;
  endtask

  initial begin
    reset = 1'b1;
    i_flush = 1'b0;
    drive0(1'b0, 4'd0, 8'd0, 32'd0, 4'd0, 1'b0);
    drive1(1'b0, 4'd0, 8'd0, 32'd0);

    // Reset hold, including requests that must not be granted
    tick("rst0");
    drive0(1'b1, 4'd3, 8'h11, 32'h1, 4'd1, 1'b1);
    drive1(1'b1, 4'd4, 8'h12, 32'h2);
    tick("rst1");
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_result", 64'(o_result), 64'd0);
    drive0(1'b0, 4'd0, 8'd0, 32'd0, 4'd0, 1'b0);
    drive1(1'b0, 4'd0, 8'd0, 32'd0);
    tick("rst2");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick("idle");
    chk("idle_valid", 64'(o_valid), 64'd0);

    // req0 only
    drive0(1'b1, 4'd5, 8'h21, 32'hDEADBEEF, 4'd2, 1'b0);
    tick("req0");
    drive0(1'b0, 4'd0, 8'd0, 32'd0, 4'd0, 1'b0);
    chk("req0_valid", 64'(o_valid), 64'd1);
    chk("req0_dst", 64'(o_dst_rob), 64'd5);
    chk("req0_fid", 64'(o_fid), 64'h21);
    chk("req0_result", 64'(o_result), 64'hDEADBEEF);
    chk("req0_cd", 64'(o_cmtdelay), 64'd2);
    chk("req0_src", 64'(o_src), 64'd0);
    tick("req0_gap");

    // req1 only
    drive1(1'b1, 4'd9, 8'h33, 32'h12345678);
    tick("req1");
    drive1(1'b0, 4'd0, 8'd0, 32'd0);
    chk("req1_valid", 64'(o_valid), 64'd1);
    chk("req1_src", 64'(o_src), 64'd1);
    chk("req1_cd", 64'(o_cmtdelay), 64'd0);
    chk("req1_ls", 64'(o_lsmiss), 64'd0);
    chk("req1_sg", 64'(o_starve_grant), 64'd0);
    chk("req1_res", 64'(o_result), 64'h12345678);
    tick("req1_gap");

    // Starvation: both held valid for 8 cycles
    drive0(1'b1, 4'd1, 8'h40, 32'hA0A0A0A0, 4'd3, 1'b1);
    drive1(1'b1, 4'd2, 8'h50, 32'hB0B0B0B0);
    grant1_seq = '0;
    for (int i = 0; i < 8; i++) begin
      tick("starve");
      if (i == 3) chk("starve_pulse", 64'(o_starve_grant), 64'd1);
    end
    chk("starve_seq", 64'(grant1_seq), 64'(8'b0001_0001));
    chk("starve_pulse2", 64'(o_starve_grant), 64'd1);

    // Flush clears a starvation count of 2
    tick("pre_flush_a");
    tick("pre_flush_b");
    i_flush = 1'b1;
    tick("flush");
    i_flush = 1'b0;
    chk("flush_valid", 64'(o_valid), 64'd0);
    chk("flush_sg", 64'(o_starve_grant), 64'd0);
    grant1_seq = '0;
    for (int i = 0; i < 4; i++) tick("post_flush");
    chk("post_flush_seq", 64'(grant1_seq[3:0]), 64'(4'b0001));
    drive0(1'b0, 4'd0, 8'd0, 32'd0, 4'd0, 1'b0);
    drive1(1'b0, 4'd0, 8'd0, 32'd0);
    tick("drain");

    // Back-to-back req0, then idle
    valid_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      drive0(1'b1, 4'(i + 6), 8'(8'h70 + i), 32'hC0DE0000 + 32'(i), 4'(i), 1'b0);
      tick("b2b");
    end
    drive0(1'b0, 4'd0, 8'd0, 32'd0, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) tick("b2b_idle");
    chk("b2b_count", 64'(valid_cnt), 64'd4);
    chk("b2b_hold", 64'(o_result), 64'hC0DE0003);
    chk("b2b_fid", 64'(o_fid), 64'h73);

    // Random traffic; a valid request that was not granted stays put
    for (int i = 0; i < 400; i++) begin
      reset   = ($urandom_range(0, 63) == 0);
      i_flush = ($urandom_range(0, 15) == 0);
      tick("rand");
      if (!(i_req0_valid && m_w != 0))
        drive0(($urandom_range(0, 3) != 0), 4'($urandom), 8'($urandom),
               $urandom, 4'($urandom), 1'($urandom));
      if (!(i_req1_valid && m_w != 1))
        drive1(($urandom_range(0, 2) != 0), 4'($urandom), 8'($urandom), $urandom);
    end
    reset = 1'b0;
    i_flush = 1'b0;
    drive0(1'b0, 4'd0, 8'd0, 32'd0, 4'd0, 1'b0);
    drive1(1'b0, 4'd0, 8'd0, 32'd0);
    tick("final");
    tick("final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
